// File: rtl/button_conditioner_bank.sv
// button_conditioner_bank
// N-channel push-button conditioner. Each channel has a two-flop synchroniser,
// a stable-count debouncer, one-cycle press/release strobes and an optional
// hold-to-auto-repeat on the press strobe.
module button_conditioner_bank #(
  parameter int unsigned      N_CH            = 3,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000,
  parameter int unsigned      REPEAT_DELAY    = 25000000,
  parameter int unsigned      REPEAT_RATE     = 5000000,
  parameter logic [N_CH-1:0]  REPEAT_EN       = '1,
  parameter logic [N_CH-1:0]  ACTIVE_LOW      = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_repeat,
  output logic            any_press
);

  localparam int unsigned DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RCNT_W = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RDLY_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RATE_LAST = RCNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_HELD,
    ST_HOLD_DELAY,
    ST_REPEATING
  } state_t;

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    logic                r_sync1;
    logic                r_sync2;
    logic [DCNT_W-1:0]   r_dcnt;
    logic                r_level;
    logic [RCNT_W-1:0]   r_rcnt;
    logic                r_press;
    logic                r_release;
    state_t              r_state;
    logic                w_flip;
    logic                w_rise;
    logic                w_fall;

    // Two-flop synchroniser; polarity normalised so 1 always means pressed
    always_ff @(posedge clk) begin
      if (reset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= btn_in[g] ^ ACTIVE_LOW[g];
        r_sync2 <= r_sync1;
      end
    end

    // The FSM reacts to the debounced edge in the same cycle the level flips,
    // so strobes line up with btn_level rather than trailing it by one cycle.
    always_comb begin
      w_flip = (r_sync2 != r_level) && (r_dcnt == DCNT_LAST);
      w_rise = w_flip && r_sync2;
      w_fall = w_flip && !r_sync2;
    end

    // Stable-count debounce: any agreement with the current level restarts the count
    always_ff @(posedge clk) begin
      if (reset) begin
        r_dcnt  <= '0;
        r_level <= 1'b0;
      end else if (r_sync2 == r_level) begin
        r_dcnt  <= '0;
      end else if (r_dcnt == DCNT_LAST) begin
        r_level <= r_sync2;
        r_dcnt  <= '0;
      end else begin
        r_dcnt  <= r_dcnt + 1'b1;
      end
    end

    // Press/release strobes and hold-to-repeat sequencing; release beats repeat expiry
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state   <= ST_RELEASED;
        r_rcnt    <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        case (r_state)
          ST_RELEASED: begin
            if (w_rise) begin
              r_press <= 1'b1;
              r_rcnt  <= '0;
              r_state <= REPEAT_EN[g] ? ST_HOLD_DELAY : ST_HELD;
            end
          end
          ST_HELD: begin
            if (w_fall) begin
              r_release <= 1'b1;
              r_rcnt    <= '0;
              r_state   <= ST_RELEASED;
            end
          end
          ST_HOLD_DELAY: begin
            if (w_fall) begin
              r_release <= 1'b1;
              r_rcnt    <= '0;
              r_state   <= ST_RELEASED;
            end else if (r_rcnt == RDLY_LAST) begin
              r_press <= 1'b1;
              r_rcnt  <= '0;
              r_state <= ST_REPEATING;
            end else begin
              r_rcnt  <= r_rcnt + 1'b1;
            end
          end
          ST_REPEATING: begin
            if (w_fall) begin
              r_release <= 1'b1;
              r_rcnt    <= '0;
              r_state   <= ST_RELEASED;
            end else if (r_rcnt == RATE_LAST) begin
              r_press <= 1'b1;
              r_rcnt  <= '0;
            end else begin
              r_rcnt  <= r_rcnt + 1'b1;
            end
          end
          default: begin
            r_rcnt  <= '0;
            r_state <= ST_RELEASED;
          end
        endcase
      end
    end

    assign btn_level[g]   = r_level;
    assign btn_press[g]   = r_press;
    assign btn_release[g] = r_release;
    assign btn_repeat[g]  = (r_state == ST_REPEATING);
  end

  assign any_press = |btn_press;

endmodule

// File: tb/tb_button_conditioner_bank.sv
// tb_button_conditioner_bank
// Two instances share the pins: u0 is active-high on all channels, u1 has
// channel 0 active-low. A behavioural model tracks both and is compared every
// cycle; directed scenarios add literal timing expectations.
module tb_button_conditioner_bank;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 5;
  localparam logic [2:0] REN = 3'b011;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] btn_in = 3'b000;

  logic [2:0] lv0, pr0, rl0, rp0;
  logic       ap0;
  logic [2:0] lv1, pr1, rl1, rp1;
  logic       ap1;

  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  always #5 clk = ~clk;

  button_conditioner_bank #(
    .N_CH(3), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
    .REPEAT_EN(REN), .ACTIVE_LOW(3'b000)
  ) u0 (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_level(lv0), .btn_press(pr0), .btn_release(rl0),
    .btn_repeat(rp0), .any_press(ap0)
  );

  button_conditioner_bank #(
    .N_CH(3), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
    .REPEAT_EN(REN), .ACTIVE_LOW(3'b001)
  ) u1 (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_level(lv1), .btn_press(pr1), .btn_release(rl1),
    .btn_repeat(rp1), .any_press(ap1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Level flips once the last D synchronised samples taken since the previous
  // flip all disagree with it. Repeats follow from elapsed time since the press.
  logic [2:0]   m_p1[2], m_p2[2], m_lv[2], m_pr[2], m_rl[2], m_rp[2];
  logic [D-1:0] m_win[2][3];
  int           m_nv[2][3];
  bit           m_held[2][3];
  int unsigned  m_pt[2][3];
  int unsigned  m_t = 0;
  bit           m_armed = 1'b0;

  always @(posedge clk) begin
    logic        s;
    int unsigned d;
    logic [2:0]  al;
    m_t++;
    for (int k = 0; k < 2; k++) begin
      al = (k == 1) ? 3'b001 : 3'b000;
      m_pr[k] = '0;
      m_rl[k] = '0;
      for (int c = 0; c < 3; c++) begin
        if (reset) begin
          m_p1[k][c] = 1'b0; m_p2[k][c] = 1'b0; m_lv[k][c] = 1'b0;
          m_rp[k][c] = 1'b0; m_held[k][c] = 1'b0; m_nv[k][c] = 0;
          m_win[k][c] = '0;
        end else begin
          s = m_p2[k][c];
          m_p2[k][c] = m_p1[k][c];
          m_p1[k][c] = btn_in[c] ^ al[c];
          m_win[k][c] = {m_win[k][c][D-2:0], s};
          if (m_nv[k][c] < D) m_nv[k][c]++;
          if (m_nv[k][c] == D && m_win[k][c] == {D{~m_lv[k][c]}}) begin
            m_lv[k][c] = ~m_lv[k][c];
            m_nv[k][c] = 0;
            if (m_lv[k][c]) begin
              m_pr[k][c] = 1'b1; m_held[k][c] = 1'b1; m_pt[k][c] = m_t;
            end else begin
              m_rl[k][c] = 1'b1; m_held[k][c] = 1'b0;
            end
          end else if (m_held[k][c] && REN[c]) begin
            d = m_t - m_pt[k][c];
            if (d >= RD && ((d - RD) % RR) == 0) m_pr[k][c] = 1'b1;
          end
          m_rp[k][c] = m_held[k][c] && REN[c] && ((m_t - m_pt[k][c]) >= RD);
        end
      end
    end
    if (reset) m_armed = 1'b1;
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (m_armed) begin
      chk("model_u0", {19'd0, lv0, pr0, rl0, rp0, ap0},
          {19'd0, m_lv[0], m_pr[0], m_rl[0], m_rp[0], |m_pr[0]});
      chk("model_u1", {19'd0, lv1, pr1, rl1, rp1, ap1},
          {19'd0, m_lv[1], m_pr[1], m_rl[1], m_rp[1], |m_pr[1]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int first;
    int cnt;
    int rcnt;

    reset = 1'b1;
    btn_in = 3'b000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_state", {19'd0, lv0, pr0, rl0, rp0, ap0}, 32'd0);

    // 1: clean press on ch0, press pulse at E5
    btn_in[0] = 1'b1;
    @(posedge clk);            // E0
    step(4);                   // E4
    chk("t1_e4_level", {29'd0, lv0}, 32'd0);
    chk("t1_e4_press", {29'd0, pr0}, 32'd0);
    step(1);                   // E5
    chk("t1_e5_press", {29'd0, pr0}, 32'd1);
    chk("t1_e5_level", {29'd0, lv0}, 32'd1);
    chk("t1_e5_any", {31'd0, ap0}, 32'd1);
    step(1);
    chk("t1_e6_press", {29'd0, pr0}, 32'd0);
    @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (12) @(negedge clk);

    // 2: bounce 1,0,1 at 2-cycle spacing then hold; one press 5 edges after last change
    btn_in[0] = 1'b1;
    first = -1;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (pr0[0]) begin
        cnt++;
        if (first < 0) first = i;
      end
      if (i == 1) btn_in[0] = 1'b0;
      if (i == 3) btn_in[0] = 1'b1;
    end
    chk("t2_press_count", cnt, 32'd1);
    chk("t2_press_edge", first, 32'd9);
    @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (12) @(negedge clk);

    // 3: hold ch1 with repeat enabled
    btn_in[1] = 1'b1;
    @(posedge clk);
    step(5);                   // P
    chk("t3_p_press", {31'd0, pr0[1]}, 32'd1);
    step(9);                   // P+9
    chk("t3_p9_press", {31'd0, pr0[1]}, 32'd0);
    chk("t3_p9_repeat", {31'd0, rp0[1]}, 32'd0);
    step(1);                   // P+10
    chk("t3_p10_press", {31'd0, pr0[1]}, 32'd1);
    chk("t3_p10_repeat", {31'd0, rp0[1]}, 32'd1);
    step(1);
    chk("t3_p11_press", {31'd0, pr0[1]}, 32'd0);
    step(4);                   // P+15
    chk("t3_p15_press", {31'd0, pr0[1]}, 32'd1);
    step(5);                   // P+20
    chk("t3_p20_press", {31'd0, pr0[1]}, 32'd1);
    repeat (20) @(negedge clk);
    btn_in[1] = 1'b0;
    rcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (rl0[1]) rcnt++;
    end
    chk("t3_release_count", rcnt, 32'd1);
    chk("t3_repeat_off", {31'd0, rp0[1]}, 32'd0);

    // 4: hold ch2 (no repeat) 40 cycles
    @(negedge clk);
    btn_in[2] = 1'b1;
    cnt = 0;
    rcnt = 0;
    for (int i = 0; i < 45; i++) begin
      step(1);
      if (pr0[2]) cnt++;
      if (rp0[2]) rcnt++;
    end
    chk("t4_press_count", cnt, 32'd1);
    chk("t4_repeat_cycles", rcnt, 32'd0);
    @(negedge clk);
    btn_in[2] = 1'b0;
    repeat (10) @(negedge clk);

    // 5: active-low ch0 on u1 has been pressed (pin low); raise pin to release
    chk("t5_al_level", {31'd0, lv1[0]}, 32'd1);
    btn_in[0] = 1'b1;
    @(posedge clk);            // E0
    step(4);
    chk("t5_e4_release", {31'd0, rl1[0]}, 32'd0);
    step(1);                   // E5 = P for u0 ch0
    chk("t5_e5_release", {31'd0, rl1[0]}, 32'd1);
    chk("t5_e5_level", {31'd0, lv1[0]}, 32'd0);
    chk("t5_u0_press", {31'd0, pr0[0]}, 32'd1);

    // 6: reset while u0 ch0 is repeating, pin kept pressed
    step(12);
    chk("t6_repeating", {31'd0, rp0[0]}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);            // R
    #1;
    chk("t6_reset_u0", {19'd0, lv0, pr0, rl0, rp0, ap0}, 32'd0);
    chk("t6_reset_u1", {19'd0, lv1, pr1, rl1, rp1, ap1}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(5);                   // R+5
    chk("t6_r5_press", {31'd0, pr0[0]}, 32'd0);
    chk("t6_r5_release", {31'd0, rl0[0]}, 32'd0);
    step(1);                   // R+6
    chk("t6_r6_press", {31'd0, pr0[0]}, 32'd1);

    // Randomised phase: sporadic toggles give both bounces and long holds
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 599) == 0);
      for (int c = 0; c < 3; c++)
        if ($urandom_range(0, 13) == 0) btn_in[c] = ~btn_in[c];
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
